inert_sensor_resp: RTL and testbench
====================================

Name: inert_sensor_resp

Overview:
SPI responder (slave) emulating the inertial sensor that sits on the far end of the SS_n/SCLK/MOSI/MISO/INT link driven by the inertial interface master. It decodes 16-bit frames (R/W, 7-bit address, 8-bit data), serves a small register file, and publishes a pitch-rate sample every INT_PERIOD clocks. It raises INT when data-ready is enabled. It is used as the synthesizable sensor stand-in for the segway core bench and FPGA bring-up.

Parameters:
INT_PERIOD, 20'd1000, clk cycles between pitch-rate samples (minimum 64).
WHO_AM_I_VAL, 8'h6A, value returned at address 0x0F.

Ports:
clk  input  1  system clock
rst  input  1  asynchronous reset, active-high
SS_n  input  1  SPI select from master, active-low
SCLK  input  1  SPI clock from master, mode 0 (idle low)
MOSI  input  1  SPI data from master, sampled on SCLK rise
MISO  output  1  SPI data to master, changes on SCLK fall
INT  output  1  data-ready interrupt, active-high
ptch_rt  input  16  signed pitch-rate value sampled at each sample tick
cfg_done  output  1  high once INT1_CTRL[1]=1 and CTRL2_G!=0

Behaviour:
- Reset (async, rst=1): all outputs 0. Registers: INT1_CTRL=0, CTRL2_G=0, shadow pitch=0. Period counter=0, bit counter=0, pending=0.
- SS_n, SCLK, MOSI are double-flopped into clk. Edges are detected from the 2nd/3rd flop. SCLK high/low phase must be ≥4 clk.
- Frame start: synchronized SS_n falling edge clears the bit counter and shift register.
- Each SCLK rise with SS_n low: shift MOSI into cmd_sr[15:0] MSB-first; bit_cnt++ (saturates at 16).
- After the 8th rise: R/W=cmd_sr[7] (1=read), addr=cmd_sr[6:0]. On a read, load tx_sr with the register read value, or 0x00 if unmapped.
- SCLK falls while bit_cnt is 8..15: MISO=tx_sr[7], then shift left. MISO=0 when SS_n is high or during the command byte.
- Frame end: SS_n rising edge. Commit only if bit_cnt==16.
  - Write: update addressed register. Writes to read-only or unmapped addresses are ignored.
  - Read of 0x23: clear INT.
  - bit_cnt≠16: abort. No write, no INT clear, counters reset.
- Register map:
  - 0x0F WHO_AM_I, RO.
  - 0x0D INT1_CTRL, RW.
  - 0x11 CTRL2_G, RW.
  - 0x22 PITCH_L = shadow[7:0], RO.
  - 0x23 PITCH_H = shadow[15:8], RO.
- Sample tick: the period counter counts 0..INT_PERIOD-1 while CTRL2_G!=0, and holds at 0 otherwise. The tick occurs at the wrap.
- At tick:
  - SS_n high (idle): shadow<=ptch_rt; INT<=INT1_CTRL[1] one clk later.
  - Frame in progress: set pending and capture ptch_rt into a hold register.
  - On the SS_n rise, load shadow from hold, clear pending, then set INT. Shadow bytes therefore stay coherent within a frame.
- Simultaneous INT clear (0x23 read commit) and shadow load from pending: set wins, INT=1.
- Writing INT1_CTRL[1]=0 clears INT at commit.
- cfg_done: combinational from the registers.
- Reset mid-frame: frame discarded, all state to reset values.
- Latency: MISO first data bit valid ≤4 clk after the 8th SCLK fall. INT is asserted 1 clk after the shadow load.
- State machine: IDLE (SS_n high) -> CMD (bit_cnt 0..7) -> DATA (bit_cnt 8..15) -> DONE (bit_cnt 16, await SS_n rise) -> IDLE.
  - SS_n rise from any state -> IDLE (commit only from DONE).
  - Extra SCLK edges in DONE are ignored.

Decomposition:
- Package inert_sensor_pkg holds:
  - register address localparams: ADDR_WHO_AM_I, ADDR_INT1_CTRL, ADDR_CTRL2_G, ADDR_PITCH_L, ADDR_PITCH_H;
  - typedef enum {IDLE, CMD, DATA, DONE} spi_resp_state_t;
  - RW_READ bit constant.
- One sub-module, spi_resp_phy: synchronizers, edge detect, bit counter, shift registers, MISO. It outputs frame_done, rw, addr, wdata and takes rdata.
- Top-level inert_sensor_resp holds the register file, period counter, pending logic and INT.

Test Plan:
- Read 0x0F (MOSI frame 16'h8F00) -> MISO second byte = 8'h6A; INT stays 0; no register changes.
- Write 0x0D=0x02, then 0x11=0x50 -> cfg_done=1. With ptch_rt=16'hF123, INT rises INT_PERIOD+1 clk after the 0x11 commit.
- With INT=1: read 0x22 -> 8'h23, INT stays 1. Then read 0x23 -> 8'hF1, INT=0 one clk after the SS_n rise.
- Tick lands mid-frame during a 0x22 read (ptch_rt changed to 16'h0456) -> that frame returns old byte 8'h23; shadow=16'h0456 and INT=1 after the SS_n rise.
- Aborted write (SS_n rises after 12 bits of 16'h0D00) -> INT1_CTRL still 0x02; the next full frame decodes correctly.
- Read unmapped 0x40 -> 8'h00. Assert rst mid-frame -> MISO=0, INT=0, cfg_done=0, next WHO_AM_I read correct.

Source files
------------

// File: rtl/inert_sensor_pkg.sv
// Shared register addresses, frame constants and responder FSM encoding
// for the inertial sensor stand-in.
package inert_sensor_pkg;

  localparam logic [6:0] ADDR_WHO_AM_I  = 7'h0F;
  localparam logic [6:0] ADDR_INT1_CTRL = 7'h0D;
  localparam logic [6:0] ADDR_CTRL2_G   = 7'h11;
  localparam logic [6:0] ADDR_PITCH_L   = 7'h22;
  localparam logic [6:0] ADDR_PITCH_H   = 7'h23;

  localparam logic RW_READ = 1'b1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMD  = 2'd1,
    DATA = 2'd2,
    DONE = 2'd3
  } spi_resp_state_t;

endpackage

// File: rtl/inert_sensor_resp_phy.sv
// SPI mode-0 responder front end: synchronizers, edge detection, frame FSM,
// command/data shift registers and MISO drive.
module spi_resp_phy
  import inert_sensor_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            ss_n_i,
  input  logic            sclk_i,
  input  logic            mosi_i,
  input  logic [7:0]      rdata_i,
  output logic            miso_o,
  output logic            frame_done_o,
  output logic            frame_end_o,
  output logic            busy_o,
  output logic            rw_o,
  output logic [6:0]      addr_o,
  output logic [7:0]      wdata_o,
  output spi_resp_state_t state_o
);

  logic [2:0]      ss_sync_q, sclk_sync_q;
  logic [1:0]      mosi_sync_q;
  spi_resp_state_t state_q, state_d;
  logic [4:0]      bit_cnt_q, bit_cnt_d;
  logic [15:0]     cmd_sr_q, cmd_sr_d;
  logic [7:0]      cmd_q, cmd_d;
  logic [7:0]      tx_sr_q, tx_sr_d;
  logic            load_q, load_d;
  logic            miso_q, miso_d;

  logic ss_fall, ss_rise, sclk_rise, sclk_fall, mosi_s;

  // Select synchronizer resets to 1 so releasing reset with SS_n idle is not a frame start.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ss_sync_q   <= 3'b111;
      sclk_sync_q <= 3'b000;
      mosi_sync_q <= 2'b00;
    end else begin
      ss_sync_q   <= {ss_sync_q[1:0], ss_n_i};
      sclk_sync_q <= {sclk_sync_q[1:0], sclk_i};
      mosi_sync_q <= {mosi_sync_q[0], mosi_i};
    end
  end

  assign ss_fall   =  ss_sync_q[2] & ~ss_sync_q[1];
  assign ss_rise   = ~ss_sync_q[2] &  ss_sync_q[1];
  assign sclk_rise = ~sclk_sync_q[2] &  sclk_sync_q[1];
  assign sclk_fall =  sclk_sync_q[2] & ~sclk_sync_q[1];
  assign mosi_s    =  mosi_sync_q[1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      bit_cnt_q <= 5'd0;
      cmd_sr_q  <= 16'h0000;
      cmd_q     <= 8'h00;
      tx_sr_q   <= 8'h00;
      load_q    <= 1'b0;
      miso_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      cmd_sr_q  <= cmd_sr_d;
      cmd_q     <= cmd_d;
      tx_sr_q   <= tx_sr_d;
      load_q    <= load_d;
      miso_q    <= miso_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    bit_cnt_d    = bit_cnt_q;
    cmd_sr_d     = cmd_sr_q;
    cmd_d        = cmd_q;
    tx_sr_d      = tx_sr_q;
    load_d       = 1'b0;
    miso_d       = miso_q;
    frame_done_o = 1'b0;

    // Read data is fetched the cycle after the command byte lands in cmd_q.
    if (load_q) tx_sr_d = (cmd_q[7] == RW_READ) ? rdata_i : 8'h00;

    unique case (state_q)
      IDLE: begin
        if (ss_fall) begin
          state_d   = CMD;
          bit_cnt_d = 5'd0;
          cmd_sr_d  = 16'h0000;
          miso_d    = 1'b0;
        end
      end
      CMD: begin
        if (sclk_rise) begin
          cmd_sr_d  = {cmd_sr_q[14:0], mosi_s};
          bit_cnt_d = bit_cnt_q + 5'd1;
          if (bit_cnt_q == 5'd7) begin
            state_d = DATA;
            cmd_d   = {cmd_sr_q[6:0], mosi_s};
            load_d  = 1'b1;
          end
        end
      end
      DATA: begin
        if (sclk_rise) begin
          cmd_sr_d  = {cmd_sr_q[14:0], mosi_s};
          bit_cnt_d = bit_cnt_q + 5'd1;
          if (bit_cnt_q == 5'd15) state_d = DONE;
        end
        if (sclk_fall) begin
          miso_d  = tx_sr_q[7];
          tx_sr_d = {tx_sr_q[6:0], 1'b0};
        end
      end
      DONE: begin
      end
      default: state_d = IDLE;
    endcase

    if (ss_rise) begin
      state_d      = IDLE;
      bit_cnt_d    = 5'd0;
      miso_d       = 1'b0;
      frame_done_o = (state_q == DONE);
    end
  end

  assign miso_o      = miso_q;
  assign frame_end_o = ss_rise;
  assign busy_o      = (state_q != IDLE);
  assign rw_o        = cmd_q[7];
  assign addr_o      = cmd_q[6:0];
  assign wdata_o     = cmd_sr_q[7:0];
  assign state_o     = state_q;

endmodule

// File: rtl/inert_sensor_resp.sv
// Inertial sensor responder: register file, pitch-rate sample timer,
// frame-coherent shadow update and data-ready interrupt.
module inert_sensor_resp
  import inert_sensor_pkg::*;
#(
  parameter logic [19:0] INT_PERIOD   = 20'd1000,
  parameter logic [7:0]  WHO_AM_I_VAL = 8'h6A
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            SS_n,
  input  logic            SCLK,
  input  logic            MOSI,
  output logic            MISO,
  output logic            INT,
  input  logic [15:0]     ptch_rt,
  output logic            cfg_done,
  output spi_resp_state_t dbg_state_o
);

  logic       frame_done, frame_end, busy, rw;
  logic [6:0] addr;
  logic [7:0] wdata, rdata;

  spi_resp_phy u_phy (
    .clk          (clk),
    .rst          (rst),
    .ss_n_i       (SS_n),
    .sclk_i       (SCLK),
    .mosi_i       (MOSI),
    .rdata_i      (rdata),
    .miso_o       (MISO),
    .frame_done_o (frame_done),
    .frame_end_o  (frame_end),
    .busy_o       (busy),
    .rw_o         (rw),
    .addr_o       (addr),
    .wdata_o      (wdata),
    .state_o      (dbg_state_o)
  );

  logic [7:0]  int1_ctrl_q, int1_ctrl_d;
  logic [7:0]  ctrl2_g_q, ctrl2_g_d;
  logic [15:0] shadow_q, shadow_d;
  logic [15:0] hold_q, hold_d;
  logic        pending_q, pending_d;
  logic [19:0] per_cnt_q, per_cnt_d;
  logic        int_set_q, int_q, int_d;

  logic tick, shadow_load, commit_wr, clr_rd, clr_wr;

  always_comb begin
    rdata = 8'h00;
    unique case (addr)
      ADDR_WHO_AM_I:  rdata = WHO_AM_I_VAL;
      ADDR_INT1_CTRL: rdata = int1_ctrl_q;
      ADDR_CTRL2_G:   rdata = ctrl2_g_q;
      ADDR_PITCH_L:   rdata = shadow_q[7:0];
      ADDR_PITCH_H:   rdata = shadow_q[15:8];
      default:        rdata = 8'h00;
    endcase
  end

  assign tick      = (ctrl2_g_q != 8'h00) && (per_cnt_q == INT_PERIOD - 20'd1);
  assign commit_wr = frame_done && (rw != RW_READ);
  assign clr_rd    = frame_done && (rw == RW_READ) && (addr == ADDR_PITCH_H);
  assign clr_wr    = commit_wr && (addr == ADDR_INT1_CTRL) && !wdata[1];
  // A tick coinciding with the frame end is treated as idle: no frame left to protect.
  assign shadow_load = (tick && (!busy || frame_end)) || (frame_end && pending_q);

  always_comb begin
    int1_ctrl_d = int1_ctrl_q;
    ctrl2_g_d   = ctrl2_g_q;
    shadow_d    = shadow_q;
    hold_d      = hold_q;
    pending_d   = pending_q;
    per_cnt_d   = 20'd0;
    int_d       = int_q;

    if (ctrl2_g_q != 8'h00) per_cnt_d = tick ? 20'd0 : per_cnt_q + 20'd1;

    if (commit_wr && addr == ADDR_INT1_CTRL) int1_ctrl_d = wdata;
    if (commit_wr && addr == ADDR_CTRL2_G)   ctrl2_g_d   = wdata;

    if (shadow_load) shadow_d = tick ? ptch_rt : hold_q;
    if (frame_end) begin
      pending_d = 1'b0;
    end else if (tick && busy) begin
      pending_d = 1'b1;
      hold_d    = ptch_rt;
    end

    // A fresh sample outranks the PITCH_H read acknowledge.
    if ((clr_rd && !shadow_load) || clr_wr) int_d = 1'b0;
    if (int_set_q && int1_ctrl_q[1]) int_d = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      int1_ctrl_q <= 8'h00;
      ctrl2_g_q   <= 8'h00;
      shadow_q    <= 16'h0000;
      hold_q      <= 16'h0000;
      pending_q   <= 1'b0;
      per_cnt_q   <= 20'd0;
      int_set_q   <= 1'b0;
      int_q       <= 1'b0;
    end else begin
      int1_ctrl_q <= int1_ctrl_d;
      ctrl2_g_q   <= ctrl2_g_d;
      shadow_q    <= shadow_d;
      hold_q      <= hold_d;
      pending_q   <= pending_d;
      per_cnt_q   <= per_cnt_d;
      int_set_q   <= shadow_load;
      int_q       <= int_d;
    end
  end

  assign INT      = int_q;
  assign cfg_done = int1_ctrl_q[1] && (ctrl2_g_q != 8'h00);

endmodule

// File: tb/tb_inert_sensor_resp.sv
// Directed bench for inert_sensor_resp acting as an SPI mode-0 master.
module tb_inert_sensor_resp;
  import inert_sensor_pkg::*;

  localparam logic [19:0] P = 20'd1000;
  localparam int H = 5;

  logic            clk = 1'b0;
  logic            rst, ss_n, sclk, mosi, miso, int_o, cfg_done;
  logic [15:0]     ptch_rt;
  spi_resp_state_t dbg_state;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int rise_cyc;
  logic [7:0] rx;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  inert_sensor_resp #(.INT_PERIOD(P), .WHO_AM_I_VAL(8'h6A)) dut (
    .clk         (clk),
    .rst         (rst),
    .SS_n        (ss_n),
    .SCLK        (sclk),
    .MOSI        (mosi),
    .MISO        (miso),
    .INT         (int_o),
    .ptch_rt     (ptch_rt),
    .cfg_done    (cfg_done),
    .dbg_state_o (dbg_state)
  );

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Master side: MISO is sampled just before each SCLK rise.
  task automatic spi_frame(input logic [15:0] frame, input int nbits, input bit keep,
                           output logic [7:0] rdat);
    rdat = 8'h00;
    step(1);
    ss_n = 1'b0;
    step(H);
    for (int i = 0; i < nbits; i++) begin
      mosi = frame[15-i];
      step(H);
      if (i >= 8) rdat = {rdat[6:0], miso};
      sclk = 1'b1;
      step(H);
      sclk = 1'b0;
    end
    step(H);
    if (!keep) ss_n = 1'b1;
  endtask

  initial begin
    rst = 1'b1; ss_n = 1'b1; sclk = 1'b0; mosi = 1'b0; ptch_rt = 16'h0000;
    step(3);
    check("rst_miso", 16'(miso), 16'h0);
    check("rst_int", 16'(int_o), 16'h0);
    check("rst_cfg_done", 16'(cfg_done), 16'h0);
    check("rst_state", 16'(dbg_state), 16'(IDLE));
    rst = 1'b0;
    step(3);

    spi_frame(16'h8F00, 16, 1'b0, rx);
    check("who_am_i", 16'(rx), 16'h006A);
    step(4);
    check("who_int", 16'(int_o), 16'h0);
    check("who_cfg_done", 16'(cfg_done), 16'h0);

    spi_frame(16'h0D02, 16, 1'b0, rx);
    step(4);
    check("int1_only_cfg_done", 16'(cfg_done), 16'h0);
    ptch_rt = 16'hF123;
    spi_frame(16'h1150, 16, 1'b0, rx);
    step(int'(P) + 3);
    check("cfg_done_set", 16'(cfg_done), 16'h1);
    check("int_before_latency", 16'(int_o), 16'h0);
    step(1);
    check("int_at_latency", 16'(int_o), 16'h1);
    rise_cyc = cyc;

    spi_frame(16'hA200, 16, 1'b0, rx);
    check("pitch_l", 16'(rx), 16'h0023);
    step(4);
    check("int_after_pitch_l", 16'(int_o), 16'h1);
    spi_frame(16'hA300, 16, 1'b0, rx);
    check("pitch_h", 16'(rx), 16'h00F1);
    step(2);
    check("int_before_clear", 16'(int_o), 16'h1);
    step(1);
    check("int_cleared", 16'(int_o), 16'h0);

    while (cyc < rise_cyc + int'(P) - 80) step(1);
    ptch_rt = 16'h0456;
    spi_frame(16'hA200, 16, 1'b1, rx);
    check("midframe_old_byte", 16'(rx), 16'h0023);
    check("midframe_int_held", 16'(int_o), 16'h0);
    ss_n = 1'b1;
    step(3);
    check("pending_int_pre", 16'(int_o), 16'h0);
    step(1);
    check("pending_int_set", 16'(int_o), 16'h1);

    spi_frame(16'h0D00, 16, 1'b0, rx);
    step(4);
    check("int1_off_clears_int", 16'(int_o), 16'h0);
    check("int1_off_cfg_done", 16'(cfg_done), 16'h0);
    spi_frame(16'hA200, 16, 1'b0, rx);
    check("shadow_l_new", 16'(rx), 16'h0056);
    spi_frame(16'hA300, 16, 1'b0, rx);
    check("shadow_h_new", 16'(rx), 16'h0004);
    spi_frame(16'h0D02, 16, 1'b0, rx);

    spi_frame(16'h0D00, 12, 1'b0, rx);
    spi_frame(16'h8D00, 16, 1'b0, rx);
    check("abort_int1_kept", 16'(rx), 16'h0002);
    step(4);
    check("abort_cfg_done", 16'(cfg_done), 16'h1);
    spi_frame(16'hC000, 16, 1'b0, rx);
    check("unmapped_read", 16'(rx), 16'h0000);
    spi_frame(16'h0F55, 16, 1'b0, rx);
    spi_frame(16'h8F00, 16, 1'b0, rx);
    check("ro_write_ignored", 16'(rx), 16'h006A);
    spi_frame(16'h9100, 16, 1'b0, rx);
    check("ctrl2_readback", 16'(rx), 16'h0050);

    for (int i = 0; i < 2500 && int_o !== 1'b1; i++) step(1);
    check("int_before_reset", 16'(int_o), 16'h1);
    spi_frame(16'h8F00, 10, 1'b1, rx);
    check("miso_mid_frame", 16'(miso), 16'h1);
    rst = 1'b1;
    step(1);
    check("midrst_miso", 16'(miso), 16'h0);
    check("midrst_int", 16'(int_o), 16'h0);
    check("midrst_cfg_done", 16'(cfg_done), 16'h0);
    ss_n = 1'b1; sclk = 1'b0; mosi = 1'b0;
    step(2);
    rst = 1'b0;
    step(3);
    spi_frame(16'h8F00, 16, 1'b0, rx);
    check("post_rst_who_am_i", 16'(rx), 16'h006A);
    spi_frame(16'h8D00, 16, 1'b0, rx);
    check("post_rst_int1", 16'(rx), 16'h0000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
